// File: rtl/cla_serial_seq.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit carry-lookahead unit processes
// one nibble per clock, LSB first, behind valid/ready handshakes on both sides.

module cla_clu4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       c_in,
    output logic [3:0] c
);
    assign c[0] = g[0] | (p[0] & c_in);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);
endmodule

module cla_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, carry_out_q, overflow_q;

    logic [3:0] a_nib, b_nib, g, p, c, sum_nib;
    logic       accept;

    assign accept  = (state_q == IDLE) & valid_i;
    assign a_nib   = a_q[{cnt_q, 2'b00} +: 4];
    assign b_nib   = b_q[{cnt_q, 2'b00} +: 4];
    assign g       = a_nib & b_nib;
    assign p       = a_nib ^ b_nib;
    assign sum_nib = p ^ {c[2:0], carry_q};

    cla_clu4 u_clu (
        .g    (g),
        .p    (p),
        .c_in (carry_q),
        .c    (c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i)        state_d = RUN;
            RUN:     if (cnt_q == LAST)  state_d = DONE;
            DONE:    if (ready_i)        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Running carry chains nibble to nibble; final flags latch on the last nibble
    // and hold until the next operation finishes its own last nibble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= carry_i;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[{cnt_q, 2'b00} +: 4] <= sum_nib;
            carry_q <= c[3];
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                carry_out_q <= c[3];
                overflow_q  <= c[3] ^ c[2];
            end
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign busy_o     = (state_q != IDLE);
    assign sum_o      = sum_q;
    assign carry_o    = carry_out_q;
    assign overflow_o = overflow_q;
endmodule
